// File: rtl/dmem_tag_responder_if.sv
// D-cache memory bus: processor command/address/store data out; tag response,
// completion tag and load data back from memory.
interface dmem_tag_responder_if #(
  parameter int ADDR_W = 16
);
  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [3:0]        mem2proc_response;
  logic [3:0]        mem2proc_tag;
  logic [63:0]       mem2proc_data;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data
  );
endinterface

// File: rtl/dmem_tag_responder.sv
// Tagged fixed-latency data memory: 15 outstanding transactions, tag broadcast
// MEM_LATENCY cycles after accept. Define DMEM_ALIGN_CHECK_EN to reject misaligned/out-of-range addresses.
module dmem_tag_responder #(
  parameter int MEM_LATENCY = 10,
  parameter int MEM_WORDS   = 8192,
  parameter int ADDR_W      = 16
) (
  input logic                 clock,
  input logic                 reset,
  dmem_tag_responder_if.slave bus
);
  localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [4:0] CNT_INIT = 5'(MEM_LATENCY - 1);
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;

  logic [63:0] mem_q [MEM_WORDS];

  logic [15:1] busy_q, busy_d;
  logic [15:1] load_q, load_d;
  logic [4:0]  cnt_q  [1:15];
  logic [4:0]  cnt_d  [1:15];
  logic [63:0] data_q [1:15];
  logic [63:0] data_d [1:15];
  logic [3:0]  next_tag_q, next_tag_d;
  logic [3:0]  tag_q, tag_d;
  logic [63:0] rdata_q, rdata_d;

  logic [31:0]      word_full;
  logic [IDX_W-1:0] word_idx;
  logic             is_load, is_store, addr_ok, accept;
  logic [63:0]      capture;
  logic [4:0]       n_complete;
  logic             unused_addr_lsbs;

  always_comb begin
    word_full = 32'(bus.proc2mem_addr[ADDR_W-1:3]);
    word_idx  = IDX_W'(word_full % 32'(MEM_WORDS));
    is_load   = (bus.proc2mem_command == CMD_LOAD);
    is_store  = (bus.proc2mem_command == CMD_STORE);
`ifdef DMEM_ALIGN_CHECK_EN
    addr_ok   = (bus.proc2mem_addr[2:0] == 3'b000) && (word_full < 32'(MEM_WORDS));
`else
    addr_ok   = 1'b1;
`endif
    accept    = (is_load || is_store) && !busy_q[next_tag_q] && !reset && addr_ok;
    capture   = is_load ? mem_q[word_idx] : 64'd0;
  end

  assign unused_addr_lsbs      = ^bus.proc2mem_addr[2:0];
  assign bus.mem2proc_response = accept ? next_tag_q : 4'd0;

  // A slot completes on the edge where its countdown reaches 0, so its tag is
  // visible during cycle T+MEM_LATENCY; latency 1 completes on the accept edge itself.
  always_comb begin
    busy_d     = busy_q;
    load_d     = load_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    next_tag_d = next_tag_q;
    tag_d      = 4'd0;
    rdata_d    = 64'd0;
    n_complete = 5'd0;
    for (int i = 1; i <= 15; i++) begin
      if (busy_q[i]) begin
        cnt_d[i] = cnt_q[i] - 5'd1;
        if (cnt_q[i] == 5'd1) begin
          busy_d[i]  = 1'b0;
          tag_d      = 4'(i);
          rdata_d    = load_q[i] ? data_q[i] : 64'd0;
          n_complete = n_complete + 5'd1;
        end
      end
    end
    if (accept) begin
      next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
      if (MEM_LATENCY == 1) begin
        tag_d      = next_tag_q;
        rdata_d    = capture;
        n_complete = n_complete + 5'd1;
      end else begin
        busy_d[next_tag_q] = 1'b1;
        load_d[next_tag_q] = is_load;
        cnt_d[next_tag_q]  = CNT_INIT;
        data_d[next_tag_q] = capture;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      load_q     <= '0;
      next_tag_q <= 4'd1;
      tag_q      <= 4'd0;
      rdata_q    <= 64'd0;
      for (int i = 1; i <= 15; i++) begin
        cnt_q[i]  <= 5'd0;
        data_q[i] <= 64'd0;
      end
    end else begin
      busy_q     <= busy_d;
      load_q     <= load_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      next_tag_q <= next_tag_d;
      tag_q      <= tag_d;
      rdata_q    <= rdata_d;
    end
  end

  // Backing store survives reset.
  always_ff @(posedge clock) begin
    if (accept && is_store) begin
      mem_q[word_idx] <= bus.proc2mem_data;
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      assert (n_complete <= 5'd1);
    end
  end

  assign bus.mem2proc_tag  = tag_q;
  assign bus.mem2proc_data = rdata_q;
endmodule

// File: tb/tb_dmem_tag_responder.sv
// Directed bench for dmem_tag_responder: one instance at latency 10, one at latency 20.
module tb_dmem_tag_responder;
  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] STORE = 2'b10;
  localparam logic [63:0] BEEF = 64'h0000_0000_DEAD_BEEF;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dmem_tag_responder_if #(.ADDR_W(16)) bus_a ();
  dmem_tag_responder_if #(.ADDR_W(16)) bus_b ();

  dmem_tag_responder #(.MEM_LATENCY(10), .MEM_WORDS(8192), .ADDR_W(16)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  dmem_tag_responder #(.MEM_LATENCY(20), .MEM_WORDS(8192), .ADDR_W(16)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive one cycle, check, advance to the next cycle.
  task automatic step_a(input logic [1:0] cmd, input logic [15:0] addr, input logic [63:0] wdata,
                        input logic [3:0] exp_resp, input logic [3:0] exp_tag,
                        input logic [63:0] exp_data, input string name);
    bus_a.proc2mem_command = cmd;
    bus_a.proc2mem_addr    = addr;
    bus_a.proc2mem_data    = wdata;
    #2;
    check_output({name, " resp"}, 64'(bus_a.mem2proc_response), 64'(exp_resp));
    check_output({name, " tag"},  64'(bus_a.mem2proc_tag),      64'(exp_tag));
    check_output({name, " data"}, bus_a.mem2proc_data,          exp_data);
    @(posedge clock);
    #1;
  endtask

  task automatic step_b(input logic [1:0] cmd, input logic [15:0] addr, input logic [63:0] wdata,
                        input logic [3:0] exp_resp, input logic [3:0] exp_tag,
                        input logic [63:0] exp_data, input string name);
    bus_b.proc2mem_command = cmd;
    bus_b.proc2mem_addr    = addr;
    bus_b.proc2mem_data    = wdata;
    #2;
    check_output({name, " resp"}, 64'(bus_b.mem2proc_response), 64'(exp_resp));
    check_output({name, " tag"},  64'(bus_b.mem2proc_tag),      64'(exp_tag));
    check_output({name, " data"}, bus_b.mem2proc_data,          exp_data);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus_a.proc2mem_command = NONE;
    bus_b.proc2mem_command = NONE;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  er;
    logic [3:0]  et;
    logic [63:0] ed;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.proc2mem_command = NONE;
    bus_a.proc2mem_addr    = '0;
    bus_a.proc2mem_data    = '0;
    bus_b.proc2mem_command = NONE;
    bus_b.proc2mem_addr    = '0;
    bus_b.proc2mem_data    = '0;
    @(posedge clock);
    #1;

    $display("[TB] reset state");
    step_a(LOAD, 16'h0040, 64'd0, 4'd0, 4'd0, 64'd0, "reset_state");
    reset = 1'b0;

    // Preload instance B's word 0x40, then reset to drop the in-flight store tag.
    step_b(STORE, 16'h0040, BEEF, 4'd1, 4'd0, 64'd0, "b_preload");
    apply_reset();

    $display("[TB] store then load, latency 10");
    step_a(STORE, 16'h0040, BEEF,  4'd1, 4'd0, 64'd0, "t1_c0");
    step_a(LOAD,  16'h0040, 64'd0, 4'd2, 4'd0, 64'd0, "t1_c1");
    for (int c = 2; c <= 9; c++) step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd0, 64'd0, "t1_idle");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd1, 64'd0, "t1_c10");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd2, BEEF,  "t1_c11");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd0, 64'd0, "t1_c12");

    $display("[TB] 20 back-to-back loads, latency 10");
    apply_reset();
    for (int c = 0; c <= 30; c++) begin
      er = (c < 20) ? 4'((c % 15) + 1) : 4'd0;
      et = (c >= 10 && c < 30) ? 4'(((c - 10) % 15) + 1) : 4'd0;
      ed = (et != 4'd0) ? BEEF : 64'd0;
      step_a((c < 20) ? LOAD : NONE, 16'h0040, 64'd0, er, et, ed, "t2");
    end

    $display("[TB] load ordering against a later store");
    step_a(STORE, 16'h0080, 64'd5, 4'd6, 4'd0, 64'd0, "t4_c0");
    step_a(LOAD,  16'h0080, 64'd0, 4'd7, 4'd0, 64'd0, "t4_c1");
    step_a(STORE, 16'h0080, 64'd9, 4'd8, 4'd0, 64'd0, "t4_c2");
    step_a(LOAD,  16'h0080, 64'd0, 4'd9, 4'd0, 64'd0, "t4_c3");
    for (int c = 4; c <= 9; c++) step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd0, 64'd0, "t4_idle");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd6, 64'd0, "t4_c10");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd7, 64'd5, "t4_c11");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd8, 64'd0, "t4_c12");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd9, 64'd9, "t4_c13");
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd0, 64'd0, "t4_c14");

    $display("[TB] reset with loads in flight");
    for (int c = 0; c <= 3; c++) step_a(LOAD, 16'h0080, 64'd0, 4'(10 + c), 4'd0, 64'd0, "t5_issue");
    reset = 1'b1;
    step_a(LOAD, 16'h0080, 64'd0, 4'd0, 4'd0, 64'd0, "t5_in_reset");
    reset = 1'b0;
    for (int c = 5; c <= 25; c++) begin
      er = (c == 15) ? 4'd1 : 4'd0;
      et = (c == 25) ? 4'd1 : 4'd0;
      ed = (c == 25) ? 64'd9 : 64'd0;
      step_a((c == 15) ? LOAD : NONE, 16'h0080, 64'd0, er, et, ed, "t5");
    end
    step_a(NONE, 16'h0, 64'd0, 4'd0, 4'd0, 64'd0, "t5_end");

    $display("[TB] misaligned load @0x43");
    for (int c = 0; c <= 12; c++) begin
`ifdef DMEM_ALIGN_CHECK_EN
      er = (c == 0) ? 4'd0 : ((c == 1) ? 4'd2 : 4'd0);
      et = (c == 11) ? 4'd2 : 4'd0;
`else
      er = (c == 0) ? 4'd2 : ((c == 1) ? 4'd3 : 4'd0);
      et = (c == 10) ? 4'd2 : ((c == 11) ? 4'd3 : 4'd0);
`endif
      ed = (et != 4'd0) ? BEEF : 64'd0;
      step_a((c <= 1) ? LOAD : NONE, (c == 0) ? 16'h0043 : 16'h0040, 64'd0, er, et, ed, "t6");
    end

    $display("[TB] saturation, latency 20");
    apply_reset();
    for (int c = 0; c <= 41; c++) begin
      er = (c < 15) ? 4'(c + 1) : ((c == 20) ? 4'd1 : 4'd0);
      et = (c >= 20 && c <= 34) ? 4'(c - 19) : ((c == 40) ? 4'd1 : 4'd0);
      ed = (et != 4'd0) ? BEEF : 64'd0;
      step_b((c <= 20) ? LOAD : NONE, 16'h0040, 64'd0, er, et, ed, "t3");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
